// File: rtl/blink_monitor_if.sv
// Signal bundle between a blink source and blink_monitor.
// The source drives blink_i and reads the measurement results.
interface blink_monitor_if #(
  parameter int CNT_W = 24
);
  logic             blink_i;
  logic             level_o;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             locked_o;
  logic             stuck_o;

  modport master (
    output blink_i,
    input  level_o, period_o, high_o, valid_o, locked_o, stuck_o
  );

  modport slave (
    input  blink_i,
    output level_o, period_o, high_o, valid_o, locked_o, stuck_o
  );
endinterface

// File: rtl/blink_monitor.sv
// Blink monitor: synchronizes a blink line and measures its period and high time.
// Define BLINK_MONITOR_DEBOUNCE_EN to filter level changes shorter than DEBOUNCE cycles.
//
// state  | meaning
// IDLE   | after reset, waiting for the first rising edge
// ARMED  | one rising edge seen, the period in progress is measurable
// LOCKED | at least one full period captured
// STUCK  | no rising edge within TIMEOUT cycles
module blink_monitor #(
  parameter int CNT_W    = 24,
  parameter int TIMEOUT  = 2**24 - 1,
  parameter int DEBOUNCE = 4
) (
  input  logic           system1000,
  input  logic           system1000_rst,
  blink_monitor_if.slave mon
);

  if (TIMEOUT < 2 || DEBOUNCE < 1 ||
      longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_params
    $fatal(1, "blink_monitor: illegal CNT_W/TIMEOUT/DEBOUNCE combination");
  end

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    STUCK  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             level;
  logic             level_q;
  logic             rise;
  logic             timeout_hit;
  logic             capture;
  logic             locked;
  logic             stuck;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic             valid_r;

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= mon.blink_i;
      s2 <= s1;
    end
  end

`ifdef BLINK_MONITOR_DEBOUNCE_EN
  localparam int             DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic [DB_W-1:0] db_cnt;

  // level follows s2 only once s2 has disagreed with it for DEBOUNCE edges in a row
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (s2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      level  <= s2;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end
`else
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      level <= 1'b0;
    end else begin
      level <= s2;
    end
  end
`endif

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise        = level & ~level_q;
  assign timeout_hit = (run_cnt >= TIMEOUT_C);

  // Both counters restart at 1 so a capture on the next rise reads the exact cycle distance.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      run_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      run_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (run_cnt != CNT_MAX) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      if (level && (hi_cnt != CNT_MAX)) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rise always takes priority over a timeout reached in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ARMED;
        end else if (timeout_hit) begin
          state_nxt = STUCK;
        end
      end
      ARMED, LOCKED: begin
        if (rise) begin
          state_nxt = LOCKED;
        end else if (timeout_hit) begin
          state_nxt = STUCK;
        end
      end
      STUCK: begin
        if (rise) begin
          state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    locked  = 1'b0;
    stuck   = 1'b0;
    case (state)
      ARMED:   capture = rise;
      LOCKED: begin
        capture = rise;
        locked  = 1'b1;
      end
      STUCK:   stuck = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      period_r <= '0;
      high_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= capture;
      if (capture) begin
        period_r <= run_cnt;
        high_r   <= hi_cnt;
      end
    end
  end

  assign mon.level_o  = level;
  assign mon.period_o = period_r;
  assign mon.high_o   = high_r;
  assign mon.valid_o  = valid_r;
  assign mon.locked_o = locked;
  assign mon.stuck_o  = stuck;

endmodule
